// File: rtl/call_return_ctrl_pkg.sv
// Shared state encodings and fault codes for the call/return stack initiator.
package call_return_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PUSH     = 3'd1,
    S_POP      = 3'd2,
    S_POP_WAIT = 3'd3,
    S_LOAD     = 3'd4,
    S_FAULT    = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    FLT_NONE = 2'b00,
    FLT_OVF  = 2'b01,
    FLT_UNF  = 2'b10,
    FLT_BOTH = 2'b11
  } fault_e;

endpackage

// File: rtl/call_return_ctrl_if.sv
// Control/data lines between the call/return initiator and the hardware LIFO stack.
interface call_return_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             stk_c;
  logic             stk_en;
  logic [WIDTH-1:0] stk_push;
  logic [WIDTH-1:0] stk_peek;
  logic             stk_full;
  logic             stk_not_empty;

  modport master (
    output stk_c, stk_en, stk_push,
    input  stk_peek, stk_full, stk_not_empty
  );

  modport slave (
    input  stk_c, stk_en, stk_push,
    output stk_peek, stk_full, stk_not_empty
  );
endinterface

// File: rtl/call_return_ctrl.sv
// Call/return sequencer front-end: drives push/pop on the LIFO stack, returns the
// PC load value, flags overflow/underflow/conflict as a sticky fault, tracks depth.
module call_return_ctrl
  import call_return_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] target,
  output logic             ready,
  output logic             pc_load,
  output logic [WIDTH-1:0] pc_out,
  output logic             fault,
  output logic [1:0]       fault_code,
  input  logic             fault_ack,
  output logic [DEPTH:0]   depth_cnt,
  call_return_ctrl_if.master stk
);

  localparam logic [DEPTH:0] DEPTH_MAX = (DEPTH+1)'(1) << DEPTH;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] push_q, push_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  fault_e           code_q, code_d;
  logic [DEPTH:0]   depth_q, depth_d;
  logic             stk_en_q, stk_c_q, pc_load_q, ready_q, fault_q;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    push_d   = push_q;
    pc_d     = pc_q;
    code_d   = code_q;
    depth_d  = depth_q;
    unique case (state_q)
      S_IDLE: begin
        if (call && ret) begin
          state_d = S_FAULT;
          code_d  = FLT_BOTH;
        end else if (call) begin
          if (stk.stk_full) begin
            state_d = S_FAULT;
            code_d  = FLT_OVF;
          end else begin
            target_d = target;
            push_d   = pc_in + WIDTH'(1);
            state_d  = S_PUSH;
          end
        end else if (ret) begin
          if (!stk.stk_not_empty) begin
            state_d = S_FAULT;
            code_d  = FLT_UNF;
          end else begin
            state_d = S_POP;
          end
        end
      end
      S_PUSH: begin
        if (depth_q != DEPTH_MAX) depth_d = depth_q + (DEPTH+1)'(1);
        pc_d    = target_q;
        state_d = S_LOAD;
      end
      S_POP: begin
        if (depth_q != '0) depth_d = depth_q - (DEPTH+1)'(1);
        state_d = S_POP_WAIT;
      end
      S_POP_WAIT: begin
        pc_d    = stk.stk_peek;
        state_d = S_LOAD;
      end
      S_LOAD: state_d = S_IDLE;
      S_FAULT: begin
        if (fault_ack) begin
          state_d = S_IDLE;
          code_d  = FLT_NONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobe outputs are flopped from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= S_IDLE;
      target_q  <= '0;
      push_q    <= '0;
      pc_q      <= '0;
      code_q    <= FLT_NONE;
      depth_q   <= '0;
      stk_en_q  <= 1'b0;
      stk_c_q   <= 1'b0;
      pc_load_q <= 1'b0;
      ready_q   <= 1'b1;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      push_q    <= push_d;
      pc_q      <= pc_d;
      code_q    <= code_d;
      depth_q   <= depth_d;
      stk_en_q  <= (state_d == S_PUSH) || (state_d == S_POP);
      stk_c_q   <= (state_d == S_PUSH);
      pc_load_q <= (state_d == S_LOAD);
      ready_q   <= (state_d == S_IDLE);
      fault_q   <= (state_d == S_FAULT);
    end
  end

  assign ready        = ready_q;
  assign pc_load      = pc_load_q;
  assign pc_out       = pc_q;
  assign fault        = fault_q;
  assign fault_code   = code_q;
  assign depth_cnt    = depth_q;
  assign stk.stk_en   = stk_en_q;
  assign stk.stk_c    = stk_c_q;
  assign stk.stk_push = push_q;

endmodule

// File: doc/call_return_ctrl.md
Name: call_return_ctrl

Overview:
Initiator side of the processor's hardware LIFO stack. The sequencer requests a subroutine call or return, and this block drives the stack's push/pop/enable lines and consumes the stack's peek/full/not_empty outputs. It then hands the PC load value back to the sequencer. It detects overflow, underflow and conflicting requests, reports them as a sticky fault, and keeps a shadow depth count.

Parameters:
WIDTH, 8, address/data width; equals the stack's data width
DEPTH, 1, log2 of stack entry count; equals the stack's depth parameter

Ports:
clk  in  1  system clock, rising edge
clr  in  1  global clear, synchronous, active-high
call  in  1  call request; held until accepted
ret  in  1  return request; held until accepted
pc_in  in  WIDTH  current PC, sampled on call acceptance
target  in  WIDTH  call destination, sampled on call acceptance
ready  out  1  block idle and not faulted; a request is accepted on a rising edge with ready=1
pc_load  out  1  one-cycle strobe: sequencer loads pc_out
pc_out  out  WIDTH  new PC value
stk_c  out  1  stack control line: 1=push, 0=pop
stk_en  out  1  stack enable
stk_push  out  WIDTH  data value to push
stk_peek  in  WIDTH  stack top-of-stack value
stk_full  in  1  stack full flag
stk_not_empty  in  1  stack non-empty flag
fault  out  1  sticky error flag
fault_code  out  2  01 overflow, 10 underflow, 11 call and ret together, 00 none
fault_ack  in  1  clears fault; returns the block to IDLE
depth_cnt  out  DEPTH+1  shadow count of stacked entries

Behaviour:
- Reset (clr=1 at an edge): state=IDLE. All outputs are 0 except ready=1. This includes pc_load, pc_out, stk_en, stk_c, stk_push, fault, fault_code and depth_cnt. clr aborts any operation in flight; no stack op may issue on the cycle after clr. The stack receives the same clr.
- Registered outputs. stk_en is 1 only in PUSH and POP states.
- States: IDLE, PUSH, POP, POP_WAIT, LOAD, FAULT.
- IDLE, call=1 and ret=1: go to FAULT with code 11.
- IDLE, call=1 only:
  - If stk_full=1: go to FAULT with code 01.
  - Otherwise: latch target, set stk_push = pc_in+1 (mod 2^WIDTH), go to PUSH.
- IDLE, ret=1 only:
  - If stk_not_empty=0: go to FAULT with code 10.
  - Otherwise: go to POP.
- PUSH: stk_en=1, stk_c=1 for exactly one cycle. depth_cnt+1. Next state LOAD with pc_out=target.
- POP: stk_en=1, stk_c=0 for exactly one cycle. depth_cnt-1. Next state POP_WAIT.
- POP_WAIT: capture stk_peek into pc_out. Next state LOAD.
- LOAD: pc_load=1 for one cycle. Next state IDLE.
- Latency from the accepting edge to pc_load high: call 2 cycles, ret 3 cycles.
- FAULT:
  - ready=0, no stack activity, pc_load=0.
  - Stays in FAULT until fault_ack=1, then goes to IDLE with fault=0 and fault_code=00.
  - depth_cnt is unchanged by a fault.
- Requests while ready=0 are ignored, not queued.
- depth_cnt saturates at 2^DEPTH and at 0; it never wraps.
- pc_in+1 wraps from 2^WIDTH-1 to 0 with no fault.
- fault_ack in a non-FAULT state has no effect.

Decomposition:
- Shared definitions file holds the state encodings (3-bit) and the fault codes FLT_NONE, FLT_OVF, FLT_UNF, FLT_BOTH.
- No sub-module inside. A top-level wrapper pairs this block with one stack instance using identical WIDTH/DEPTH.

Test Plan:
- clr, pc_in=8'h10, target=8'h40, call pulse held until ready → one stk_en/stk_c=1 cycle with stk_push=8'h11; pc_load at +2 with pc_out=8'h40; depth_cnt=1.
- After the above, ret → one stk_en with stk_c=0; pc_load at +3 with pc_out=8'h11; depth_cnt=0.
- DEPTH=1: two calls, then a third with stk_full=1 → no stack op, fault=1, code 01, ready=0; fault_ack → ready=1, code 00, depth_cnt stays 2.
- ret right after clr → fault code 10, no stk_en; call and ret asserted together → fault code 11.
- clr asserted during POP_WAIT → next cycle all outputs 0, ready=1, no pc_load; pc_in=8'hFF call → stk_push=8'h00.
